// File: rtl/program_loader.sv
`default_nettype none
// ============================================================================
// Module  : program_loader
// Purpose : Boot loader. Assembles a length-prefixed little-endian byte stream
//           into 16-bit instruction writes and holds the core in reset until
//           the image is complete. Optional macro PROGRAM_LOADER_CHECKSUM_EN
//           adds a trailing mod-256 checksum byte to the frame.
// Revision: 1.0 - initial release
// ============================================================================
module program_loader #(
    parameter int ADDR_WIDTH     = 10,
    parameter int INSTR_WIDTH    = 16,
    parameter int TIMEOUT_CYCLES = 65535
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [7:0]             rx_data,
    input  logic                   rx_valid,
    output logic                   rx_ready,
    input  logic                   restart,
    output logic                   imem_wr_en,
    output logic [ADDR_WIDTH-1:0]  imem_wr_addr,
    output logic [INSTR_WIDTH-1:0] imem_wr_data,
    output logic                   core_reset,
    output logic                   load_done,
    output logic                   load_error
);

    localparam logic [2:0] c_ST_LEN_LO  = 3'd0;
    localparam logic [2:0] c_ST_LEN_HI  = 3'd1;
    localparam logic [2:0] c_ST_DATA_LO = 3'd2;
    localparam logic [2:0] c_ST_DATA_HI = 3'd3;
    localparam logic [2:0] c_ST_DONE    = 3'd4;
    localparam logic [2:0] c_ST_ERROR   = 3'd5;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
    localparam logic [2:0] c_ST_CSUM       = 3'd6;
    localparam logic [2:0] c_ST_AFTER_LAST = c_ST_CSUM;
`else
    localparam logic [2:0] c_ST_AFTER_LAST = c_ST_DONE;
`endif

    // Idle counter only ever needs to hold TIMEOUT_CYCLES-1.
    localparam int              c_TMO_W     = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [c_TMO_W-1:0] c_TMO_LAST = c_TMO_W'(TIMEOUT_CYCLES - 1);
    localparam logic [16:0]     c_MAX_WORDS = 17'(2 ** ADDR_WIDTH);

    logic [2:0]             r_state;
    logic [2:0]             w_next_state;
    logic                   w_xfer;
    logic [15:0]            w_len;
    logic                   w_len_bad;
    logic                   w_last;
    logic                   w_counting;
    logic                   w_tmo_hit;

    logic [7:0]             r_len_lo;
    logic [ADDR_WIDTH-1:0]  r_last_idx;
    logic [7:0]             r_lo;
    logic [c_TMO_W-1:0]     r_tmo;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
    logic [7:0]             r_csum;
`endif

    logic                   r_rx_ready;
    logic                   r_wr_en;
    logic [ADDR_WIDTH-1:0]  r_wr_addr;
    logic [INSTR_WIDTH-1:0] r_wr_data;
    logic                   r_core_reset;
    logic                   r_load_done;
    logic                   r_load_error;

    logic                   w_rx_ready_nxt;
    logic                   w_wr_en_nxt;
    logic                   w_core_reset_nxt;
    logic                   w_load_done_nxt;
    logic                   w_load_error_nxt;

    assign w_xfer    = rx_valid & r_rx_ready;
    assign w_len     = {rx_data, r_len_lo};
    assign w_len_bad = (w_len == 16'd0) || ({1'b0, w_len} > c_MAX_WORDS);
    // r_wr_addr already points at the word being assembled: the previous
    // write's increment lands before the next high byte can be accepted.
    assign w_last    = (r_wr_addr == r_last_idx);

    always_comb begin
        w_counting = (r_state == c_ST_LEN_HI) || (r_state == c_ST_DATA_LO) ||
                     (r_state == c_ST_DATA_HI);
`ifdef PROGRAM_LOADER_CHECKSUM_EN
        if (r_state == c_ST_CSUM) begin
            w_counting = 1'b1;
        end
`endif
    end

    assign w_tmo_hit = w_counting && !w_xfer && (r_tmo == c_TMO_LAST);

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= c_ST_LEN_LO;
        end else begin
            r_state <= w_next_state;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            c_ST_LEN_LO: begin
                if (w_xfer) w_next_state = c_ST_LEN_HI;
            end
            c_ST_LEN_HI: begin
                if (w_xfer) w_next_state = w_len_bad ? c_ST_ERROR : c_ST_DATA_LO;
            end
            c_ST_DATA_LO: begin
                if (w_xfer) w_next_state = c_ST_DATA_HI;
            end
            c_ST_DATA_HI: begin
                if (w_xfer) w_next_state = w_last ? c_ST_AFTER_LAST : c_ST_DATA_LO;
            end
`ifdef PROGRAM_LOADER_CHECKSUM_EN
            c_ST_CSUM: begin
                if (w_xfer) w_next_state = (rx_data == r_csum) ? c_ST_DONE : c_ST_ERROR;
            end
`endif
            c_ST_DONE, c_ST_ERROR: begin
                if (restart) w_next_state = c_ST_LEN_LO;
            end
            default: w_next_state = c_ST_LEN_LO;
        endcase
        if (w_tmo_hit) begin
            w_next_state = c_ST_ERROR;
        end
    end

    // ------------------------------------------------------------------
    // FSM: output logic (outputs are registered from the next state)
    // ------------------------------------------------------------------
    always_comb begin
        w_rx_ready_nxt   = (w_next_state == c_ST_LEN_LO)  || (w_next_state == c_ST_LEN_HI) ||
                           (w_next_state == c_ST_DATA_LO) || (w_next_state == c_ST_DATA_HI);
`ifdef PROGRAM_LOADER_CHECKSUM_EN
        if (w_next_state == c_ST_CSUM) begin
            w_rx_ready_nxt = 1'b1;
        end
`endif
        w_wr_en_nxt      = w_xfer && (r_state == c_ST_DATA_HI);
        w_load_done_nxt  = (w_next_state == c_ST_DONE);
        w_load_error_nxt = (w_next_state == c_ST_ERROR);
        w_core_reset_nxt = (w_next_state != c_ST_DONE);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_rx_ready   <= 1'b0;
            r_wr_en      <= 1'b0;
            r_core_reset <= 1'b1;
            r_load_done  <= 1'b0;
            r_load_error <= 1'b0;
        end else begin
            r_rx_ready   <= w_rx_ready_nxt;
            r_wr_en      <= w_wr_en_nxt;
            r_core_reset <= w_core_reset_nxt;
            r_load_done  <= w_load_done_nxt;
            r_load_error <= w_load_error_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Datapath: length capture, byte assembly, address, idle timer
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_len_lo   <= 8'd0;
            r_last_idx <= '0;
            r_lo       <= 8'd0;
            r_wr_addr  <= '0;
            r_wr_data  <= '0;
            r_tmo      <= '0;
        end else begin
            if (w_xfer && (r_state == c_ST_LEN_LO)) begin
                r_len_lo <= rx_data;
            end
            if (w_xfer && (r_state == c_ST_LEN_HI)) begin
                r_last_idx <= ADDR_WIDTH'(w_len - 16'd1);
            end
            if (w_xfer && (r_state == c_ST_DATA_LO)) begin
                r_lo <= rx_data;
            end
            if (w_xfer && (r_state == c_ST_DATA_HI)) begin
                r_wr_data <= {rx_data, r_lo};
            end
            if (restart && ((r_state == c_ST_DONE) || (r_state == c_ST_ERROR))) begin
                r_wr_addr <= '0;
            end else if (r_wr_en) begin
                r_wr_addr <= r_wr_addr + ADDR_WIDTH'(1);
            end
            if (!w_counting || w_xfer) begin
                r_tmo <= '0;
            end else begin
                r_tmo <= r_tmo + c_TMO_W'(1);
            end
        end
    end

`ifdef PROGRAM_LOADER_CHECKSUM_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_csum <= 8'd0;
        end else if (r_state == c_ST_LEN_LO) begin
            r_csum <= 8'd0;
        end else if (w_xfer && ((r_state == c_ST_DATA_LO) || (r_state == c_ST_DATA_HI))) begin
            r_csum <= r_csum + rx_data;
        end
    end
`endif

    assign rx_ready     = r_rx_ready;
    assign imem_wr_en   = r_wr_en;
    assign imem_wr_addr = r_wr_addr;
    assign imem_wr_data = r_wr_data;
    assign core_reset   = r_core_reset;
    assign load_done    = r_load_done;
    assign load_error   = r_load_error;

endmodule
`default_nettype wire

// File: tb/tb_program_loader.sv
`default_nettype none
// ============================================================================
// Module  : tb_program_loader
// Purpose : Directed self-checking bench for program_loader.
// Revision: 1.0 - initial release
// ============================================================================
module tb_program_loader;

    localparam int TMO = 16;

    logic        clk;
    logic        reset;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        rx_ready;
    logic        restart;
    logic        imem_wr_en;
    logic [9:0]  imem_wr_addr;
    logic [15:0] imem_wr_data;
    logic        core_reset;
    logic        load_done;
    logic        load_error;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;

    logic [9:0]  wq_addr[$];
    logic [15:0] wq_data[$];
    int          wq_cyc[$];
    logic [15:0] frame_words[$];
    logic [7:0]  tb_sum;

    program_loader #(
        .ADDR_WIDTH    (10),
        .INSTR_WIDTH   (16),
        .TIMEOUT_CYCLES(TMO)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .rx_data     (rx_data),
        .rx_valid    (rx_valid),
        .rx_ready    (rx_ready),
        .restart     (restart),
        .imem_wr_en  (imem_wr_en),
        .imem_wr_addr(imem_wr_addr),
        .imem_wr_data(imem_wr_data),
        .core_reset  (core_reset),
        .load_done   (load_done),
        .load_error  (load_error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Write monitor: sampled 1 time unit after each rising edge.
    always @(posedge clk) begin
        #1;
        cyc = cyc + 1;
        if (imem_wr_en === 1'b1) begin
            wq_addr.push_back(imem_wr_addr);
            wq_data.push_back(imem_wr_data);
            wq_cyc.push_back(cyc);
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish (got hang, required completion)");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic        v;
        logic [7:0]  d;
        logic        rs;
        logic [30:0] exp;
    } vec_t;

    function automatic vec_t mk(input logic v, input logic [7:0] d, input logic rs,
                                input logic rdy, input logic wr, input logic [9:0] a,
                                input logic [15:0] dat, input logic dn, input logic er,
                                input logic cr);
        vec_t t;
        t.v   = v;
        t.d   = d;
        t.rs  = rs;
        t.exp = {rdy, wr, a, dat, dn, er, cr};
        return t;
    endfunction

    function automatic logic [30:0] outs();
        return {rx_ready, imem_wr_en, imem_wr_addr, imem_wr_data, load_done, load_error, core_reset};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, required %h", name, act, exp);
        end
    endtask

    // Called at a falling edge; returns at the falling edge after the transfer.
    task automatic send_byte(input logic [7:0] b);
        int n;
        n        = 0;
        rx_valid = 1'b1;
        rx_data  = b;
        while (rx_ready !== 1'b1 && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (rx_ready !== 1'b1) begin
            n_cmp++;
            n_bad++;
            $display("FAIL send_byte: rx_ready stayed %b, required 1 within 40 cycles", rx_ready);
        end else begin
            @(negedge clk);
        end
        rx_valid = 1'b0;
    endtask

    task automatic send_frame();
        int n;
        n      = frame_words.size();
        tb_sum = 8'd0;
        send_byte(n[7:0]);
        send_byte(n[15:8]);
        foreach (frame_words[i]) begin
            send_byte(frame_words[i][7:0]);
            send_byte(frame_words[i][15:8]);
            tb_sum = tb_sum + frame_words[i][7:0] + frame_words[i][15:8];
        end
    endtask

    task automatic finish_frame();
`ifdef PROGRAM_LOADER_CHECKSUM_EN
        send_byte(tb_sum);
`endif
    endtask

    task automatic do_restart();
        restart = 1'b1;
        @(negedge clk);
        restart = 1'b0;
        @(negedge clk);
    endtask

    task automatic clear_log();
        wq_addr.delete();
        wq_data.delete();
        wq_cyc.delete();
    endtask

    function automatic logic [15:0] burst_word(input int i);
        logic [7:0] hi;
        logic [7:0] lo;
        hi = 8'(i >> 8) ^ 8'h5A;
        lo = 8'(i);
        return {hi, lo};
    endfunction

    vec_t tbl[21];
    int   bad_words;
    int   bad_gaps;

    initial begin
        rx_valid = 1'b0;
        rx_data  = 8'h00;
        restart  = 1'b0;
        reset    = 1'b1;
        repeat (2) @(negedge clk);
        check("reset_state", {1'b0, outs()}, {1'b0, 1'b0, 1'b0, 10'd0, 16'h0000, 1'b0, 1'b0, 1'b1});
        reset = 1'b0;
        #1;
        check("ready_first_cycle", {31'd0, rx_ready}, 32'd0);

`ifndef PROGRAM_LOADER_CHECKSUM_EN
        //             v  data  rs  rdy wr addr  data      dn er cr
        tbl[0]  = mk(1, 8'h02, 0,  1, 0, 10'd0, 16'h0000, 0, 0, 1);
        tbl[1]  = mk(1, 8'h00, 0,  1, 0, 10'd0, 16'h0000, 0, 0, 1);
        tbl[2]  = mk(1, 8'h34, 0,  1, 0, 10'd0, 16'h0000, 0, 0, 1);
        tbl[3]  = mk(1, 8'h12, 0,  1, 0, 10'd0, 16'h0000, 0, 0, 1);
        tbl[4]  = mk(1, 8'h78, 0,  1, 1, 10'd0, 16'h1234, 0, 0, 1);
        tbl[5]  = mk(1, 8'h56, 0,  1, 0, 10'd1, 16'h1234, 0, 0, 1);
        tbl[6]  = mk(0, 8'h00, 0,  0, 1, 10'd1, 16'h5678, 1, 0, 0);
        tbl[7]  = mk(1, 8'hFF, 0,  0, 0, 10'd2, 16'h5678, 1, 0, 0);
        tbl[8]  = mk(0, 8'h00, 1,  0, 0, 10'd2, 16'h5678, 1, 0, 0);
        tbl[9]  = mk(1, 8'h00, 0,  1, 0, 10'd0, 16'h5678, 0, 0, 1);
        tbl[10] = mk(1, 8'h00, 0,  1, 0, 10'd0, 16'h5678, 0, 0, 1);
        tbl[11] = mk(1, 8'h11, 0,  0, 0, 10'd0, 16'h5678, 0, 1, 1);
        tbl[12] = mk(0, 8'h00, 1,  0, 0, 10'd0, 16'h5678, 0, 1, 1);
        tbl[13] = mk(1, 8'h01, 0,  1, 0, 10'd0, 16'h5678, 0, 0, 1);
        tbl[14] = mk(1, 8'h04, 0,  1, 0, 10'd0, 16'h5678, 0, 0, 1);
        tbl[15] = mk(0, 8'h00, 1,  0, 0, 10'd0, 16'h5678, 0, 1, 1);
        tbl[16] = mk(1, 8'h01, 0,  1, 0, 10'd0, 16'h5678, 0, 0, 1);
        tbl[17] = mk(1, 8'h00, 0,  1, 0, 10'd0, 16'h5678, 0, 0, 1);
        tbl[18] = mk(1, 8'hCD, 0,  1, 0, 10'd0, 16'h5678, 0, 0, 1);
        tbl[19] = mk(1, 8'hAB, 0,  1, 0, 10'd0, 16'h5678, 0, 0, 1);
        tbl[20] = mk(0, 8'h00, 0,  0, 1, 10'd0, 16'hABCD, 1, 0, 0);
        for (int i = 0; i < 21; i++) begin
            @(negedge clk);
            check($sformatf("table_row_%0d", i), {1'b0, outs()}, {1'b0, tbl[i].exp});
            rx_valid = tbl[i].v;
            rx_data  = tbl[i].d;
            restart  = tbl[i].rs;
        end
        @(negedge clk);
        rx_valid = 1'b0;
        restart  = 1'b0;
`endif

        // Reset asserted mid-frame, then a fresh frame from LEN_LO.
        do_restart();
        send_byte(8'h02);
        send_byte(8'h00);
        send_byte(8'h34);
        #2 reset = 1'b1;
        #1;
        check("async_reset_mid_frame", {1'b0, outs()}, {1'b0, 1'b0, 1'b0, 10'd0, 16'h0000, 1'b0, 1'b0, 1'b1});
        @(negedge clk);
        reset = 1'b0;
        #1;
        check("ready_after_mid_reset", {31'd0, rx_ready}, 32'd0);
        @(negedge clk);
        clear_log();
        frame_words = '{16'hBEEF};
        send_frame();
        finish_frame();
        check("reload_flags", {29'd0, load_done, core_reset, load_error}, {29'd0, 3'b100});
        check("reload_count", wq_addr.size(), 32'd1);
        if (wq_addr.size() > 0) check("reload_word", {6'd0, wq_addr[0], wq_data[0]}, {6'd0, 10'd0, 16'hBEEF});

        // Idle gap of exactly TMO cycles after the first data byte.
        do_restart();
        clear_log();
        send_byte(8'h02);
        send_byte(8'h00);
        send_byte(8'h34);
        repeat (TMO) @(negedge clk);
        check("timeout_flags", {29'd0, load_error, core_reset, rx_ready}, {29'd0, 3'b110});
        check("timeout_no_write", wq_addr.size(), 32'd0);

        // Gap of TMO-1 cycles still completes.
        do_restart();
        clear_log();
        send_byte(8'h02);
        send_byte(8'h00);
        send_byte(8'h34);
        tb_sum = 8'h34;
        repeat (TMO - 1) @(negedge clk);
        check("gap_no_error", {31'd0, load_error}, 32'd0);
        send_byte(8'h12);
        send_byte(8'h78);
        send_byte(8'h56);
        tb_sum = 8'h34 + 8'h12 + 8'h78 + 8'h56;
        finish_frame();
        check("gap_done_flags", {29'd0, load_done, core_reset, load_error}, {29'd0, 3'b100});
        check("gap_count", wq_addr.size(), 32'd2);
        if (wq_addr.size() == 2) begin
            check("gap_word0", {6'd0, wq_addr[0], wq_data[0]}, {6'd0, 10'd0, 16'h1234});
            check("gap_word1", {6'd0, wq_addr[1], wq_data[1]}, {6'd0, 10'd1, 16'h5678});
        end

`ifdef PROGRAM_LOADER_CHECKSUM_EN
        do_restart();
        clear_log();
        send_byte(8'h01); send_byte(8'h00); send_byte(8'h34); send_byte(8'h12);
        send_byte(8'h46);
        check("csum_good_flags", {29'd0, load_done, core_reset, load_error}, {29'd0, 3'b100});
        do_restart();
        clear_log();
        send_byte(8'h01); send_byte(8'h00); send_byte(8'h34); send_byte(8'h12);
        send_byte(8'h47);
        check("csum_bad_flags", {29'd0, load_done, core_reset, load_error}, {29'd0, 3'b011});
        check("csum_bad_written", wq_addr.size(), 32'd1);
        if (wq_addr.size() == 1) check("csum_bad_word", {6'd0, wq_addr[0], wq_data[0]}, {6'd0, 10'd0, 16'h1234});
`endif

        // Full-size back-to-back image.
        do_restart();
        clear_log();
        frame_words.delete();
        for (int i = 0; i < 1024; i++) frame_words.push_back(burst_word(i));
        send_frame();
        finish_frame();
        rx_valid = 1'b1;
        rx_data  = 8'h99;
        repeat (3) @(negedge clk);
        check("burst_flags", {28'd0, load_done, core_reset, load_error, rx_ready}, {28'd0, 4'b1000});
        check("burst_count", wq_addr.size(), 32'd1024);
        bad_words = 0;
        bad_gaps  = 0;
        foreach (wq_addr[i]) begin
            if (i < 1024 && (wq_addr[i] !== 10'(i) || wq_data[i] !== burst_word(i))) bad_words++;
            if (i > 0 && (wq_cyc[i] - wq_cyc[i-1]) != 2) bad_gaps++;
        end
        check("burst_bad_words", bad_words, 32'd0);
        check("burst_bad_spacing", bad_gaps, 32'd0);
        rx_valid = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
